// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller and its input conditioning.
package traffic_pkg;

   // Default conditioning parameters for external inputs
   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   // Debounce state encoding; bit 1 doubles as the debounced loop level
   localparam logic [1:0] ST_LOW     = 2'b00;
   localparam logic [1:0] ST_QUAL_HI = 2'b01;
   localparam logic [1:0] ST_HIGH    = 2'b10;
   localparam logic [1:0] ST_QUAL_LO = 2'b11;

   // Light-phase encoding used by the light FSM
   typedef enum logic [1:0] {
      PH_RED    = 2'b00,
      PH_GREEN  = 2'b01,
      PH_YELLOW = 2'b10
   } light_phase_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for asynchronous external inputs.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw input through the synchronizer chain
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/sensor_qualifier.sv
// Synchronizes and debounces the vehicle loop, latches arrivals as service
// requests for the light FSM and keeps a saturating arrival count.
module sensor_qualifier
   import traffic_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor_raw,
   input  logic             grant,
   input  logic             count_clr,
   output logic             sensor,
   output logic             presence,
   output logic             arrival,
   output logic [CNT_W-1:0] vehicle_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          arrival_nxt;

   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (sensor_raw),
      .q  (s)
   );

   // Debounce transitions; the qualifying edge that completes the count moves
   // straight to the settled state so the counter never exceeds its range
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      arrival_nxt = 1'b0;
      case (state)
         ST_LOW: begin
            if (s) begin
               state_nxt = ST_QUAL_HI;
               cnt_nxt   = CW'(1);
            end
         end
         ST_QUAL_HI: begin
            if (!s) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               state_nxt   = ST_HIGH;
               cnt_nxt     = '0;
               arrival_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_nxt = ST_QUAL_LO;
               cnt_nxt   = CW'(1);
            end
         end
         default: begin
            if (s) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
      endcase
   end

   // Register debounce state, arrival pulse, request latch and arrival count;
   // grant beats a same-cycle arrival, and clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_LOW;
         cnt           <= '0;
         arrival       <= 1'b0;
         sensor        <= 1'b0;
         vehicle_count <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         arrival <= arrival_nxt;
         if (grant) begin
            sensor <= 1'b0;
         end else if (arrival_nxt) begin
            sensor <= 1'b1;
         end
         if (count_clr) begin
            vehicle_count <= '0;
         end else if (arrival_nxt && (vehicle_count != {CNT_W{1'b1}})) begin
            vehicle_count <= vehicle_count + CNT_W'(1);
         end
      end
   end

   assign presence = state[1];

endmodule

// File: tb/tb_sensor_qualifier.sv
// Scoreboard bench for sensor_qualifier: stimulus pushes the expected arrival
// events, a monitor pops and compares them whenever arrival pulses.
module tb_sensor_qualifier;

   logic       clk = 1'b0;
   logic       rst;
   logic       sensor_raw;
   logic       grant;
   logic       count_clr;
   logic       sensor;
   logic       presence;
   logic       arrival;
   logic [1:0] vehicle_count;

   typedef struct {
      int         cyc;
      logic [1:0] cnt;
      logic       sens;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   exp_count = 0;

   sensor_qualifier #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(16),
      .CNT_W          (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sensor_raw   (sensor_raw),
      .grant        (grant),
      .count_clr    (count_clr),
      .sensor       (sensor),
      .presence     (presence),
      .arrival      (arrival),
      .vehicle_count(vehicle_count)
   );

   // Free-running clock and edge counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise the loop for a full qualification, optionally colliding the
   // arrival with grant and/or count_clr, then let the loop clear again
   task automatic apply_stimulus(input bit with_grant, input bit with_clr);
      exp_t e;
      sensor_raw = 1'b1;
      if (with_clr) exp_count = 0;
      else if (exp_count < 3) exp_count++;
      e.cyc  = cyc + 18;
      e.cnt  = 2'(exp_count);
      e.sens = !with_grant;
      q.push_back(e);
      tick(17);
      check_output("arrival_early", arrival, 0);
      grant     = with_grant;
      count_clr = with_clr;
      tick(1);
      grant      = 1'b0;
      count_clr  = 1'b0;
      sensor_raw = 1'b0;
      tick(19);
      check_output("presence_cleared", presence, 0);
      tick(2);
   endtask

   // Monitor: every arrival pulse must match the oldest expected event
   always @(negedge clk) begin
      if (!rst && arrival) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_arrival: got pulse at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check_output("arrival_cycle", cyc, e.cyc);
            check_output("arrival_count", vehicle_count, e.cnt);
            check_output("arrival_sensor", sensor, e.sens);
            check_output("arrival_presence", presence, 1);
         end
      end
   end

   initial begin
      exp_t e;
      rst        = 1'b1;
      sensor_raw = 1'b1;
      grant      = 1'b0;
      count_clr  = 1'b0;

      // Reset with the loop already occupied
      tick(3);
      check_output("rst_sensor", sensor, 0);
      check_output("rst_presence", presence, 0);
      check_output("rst_arrival", arrival, 0);
      check_output("rst_count", vehicle_count, 0);

      // First arrival after release
      rst       = 1'b0;
      exp_count = 1;
      e.cyc  = cyc + 18;
      e.cnt  = 2'd1;
      e.sens = 1'b1;
      q.push_back(e);
      tick(17);
      check_output("first_arrival_early", arrival, 0);
      check_output("first_presence_early", presence, 0);
      tick(1);
      tick(1);
      check_output("arrival_one_cycle", arrival, 0);
      check_output("sensor_held", sensor, 1);

      // Service: grant five cycles after arrival clears the request
      tick(3);
      grant = 1'b1;
      tick(1);
      grant = 1'b0;
      check_output("grant_clears_sensor", sensor, 0);
      check_output("presence_during_grant", presence, 1);
      sensor_raw = 1'b0;
      tick(17);
      check_output("presence_fall_early", presence, 1);
      tick(1);
      check_output("presence_fall", presence, 0);
      tick(3);

      // Glitch of 15 cycles is rejected
      sensor_raw = 1'b1;
      tick(15);
      sensor_raw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check_output("glitch_presence", presence, 0);
      end
      check_output("glitch_count", vehicle_count, exp_count);
      check_output("glitch_sensor", sensor, 0);

      // Collision with grant, then saturation, then clear with arrival
      apply_stimulus(1'b1, 1'b0);
      check_output("collision_sensor", sensor, 0);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      check_output("saturated_count", vehicle_count, 3);
      apply_stimulus(1'b0, 1'b1);
      check_output("clr_count", vehicle_count, 0);
      check_output("clr_sensor", sensor, 1);

      // Reset partway through qualification discards progress and request
      sensor_raw = 1'b1;
      tick(12);
      rst = 1'b1;
      tick(1);
      check_output("midrst_sensor", sensor, 0);
      check_output("midrst_count", vehicle_count, 0);
      check_output("midrst_presence", presence, 0);
      rst       = 1'b0;
      exp_count = 1;
      e.cyc  = cyc + 18;
      e.cnt  = 2'd1;
      e.sens = 1'b1;
      q.push_back(e);
      tick(8);
      check_output("midrst_no_short_arrival", arrival, 0);
      tick(9);
      check_output("midrst_arrival_early", arrival, 0);
      tick(1);
      tick(3);

      check_output("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
